// File: rtl/pps_drift_monitor.sv
// pps_drift_monitor
//   PPS-disciplined oscillator drift monitor. Counts clk cycles across a
//   window of 1..15 accepted PPS periods and reports signed, saturated
//   (measured - expected) cycles through a valid/ready handshake. Edges that
//   arrive too early are rejected as glitches; a missing PPS drops the block
//   into HOLDOVER until the next edge; a result overwritten before it was
//   accepted raises a one-cycle overrun pulse.
//
//   Optional feature macro: PPS_DRIFT_STATS_EN
//     When defined, adds stats_clear_i and drift_min_o / drift_max_o
//     (running min/max of reported drift since reset or the last clear).
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   pps_i                  raw asynchronous PPS input
//   enable_i               0 forces IDLE and discards any window in progress
//   window_len_i           window length in PPS periods (0 means 1), latched
//                          at each window start
//   event_valid_o/ready_i  result handshake; data held until accepted
//   event_utc_seconds_o    accepted-PPS count at the window-end edge
//   event_drift_o          signed measured-minus-expected cycles, saturated
//   event_window_o         window length used for this result
//   event_overrun_o        pulse: a pending result was overwritten
//   pps_lost_o             pulse: no PPS within NOMINAL+TOL cycles
//   glitch_count_o         saturating count of rejected (early) edges
//   state_o                0 IDLE, 1 MEASURE, 2 HOLDOVER
module pps_drift_monitor #(
   parameter int unsigned UTC_SECONDS_WIDTH      = 32,
   parameter int unsigned DRIFT_WIDTH            = 24,
   parameter int unsigned COUNT_WIDTH            = 36,
   parameter int unsigned NOMINAL_CYCLES_PER_SEC = 614_400_000,
   parameter int unsigned TOL_CYCLES             = 61_440,
   parameter int unsigned GLITCH_CNT_WIDTH       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pps_i,
   input  logic                          enable_i,
   input  logic [3:0]                    window_len_i,
   output logic                          event_valid_o,
   input  logic                          event_ready_i,
   output logic [UTC_SECONDS_WIDTH-1:0]  event_utc_seconds_o,
   output logic signed [DRIFT_WIDTH-1:0] event_drift_o,
   output logic [3:0]                    event_window_o,
   output logic                          event_overrun_o,
   output logic                          pps_lost_o,
   output logic [GLITCH_CNT_WIDTH-1:0]   glitch_count_o,
`ifdef PPS_DRIFT_STATS_EN
   input  logic                          stats_clear_i,
   output logic signed [DRIFT_WIDTH-1:0] drift_min_o,
   output logic signed [DRIFT_WIDTH-1:0] drift_max_o,
`endif
   output logic [1:0]                    state_o
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MEASURE  = 2'd1;
   localparam logic [1:0] ST_HOLDOVER = 2'd2;

   localparam logic [COUNT_WIDTH-1:0] NOM_C   = COUNT_WIDTH'(NOMINAL_CYCLES_PER_SEC);
   localparam logic [COUNT_WIDTH-1:0] LO_C    = COUNT_WIDTH'(NOMINAL_CYCLES_PER_SEC - TOL_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] HI_C    = COUNT_WIDTH'(NOMINAL_CYCLES_PER_SEC + TOL_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] LOST_C  = COUNT_WIDTH'(NOMINAL_CYCLES_PER_SEC + TOL_CYCLES + 1);

   // Saturation bounds expressed at the difference width; ~MAX == -MAX-1.
   localparam logic signed [COUNT_WIDTH:0] SAT_MAX =
      $signed((COUNT_WIDTH+1)'((65'd1 << (DRIFT_WIDTH-1)) - 65'd1));
   localparam logic signed [COUNT_WIDTH:0] SAT_MIN = ~SAT_MAX;

   // ---------------------------------------------------------------
   // PPS synchroniser and rising-edge strobe (3 clk after the pin)
   // ---------------------------------------------------------------
   logic [2:0] sync_q;
   logic       rise_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], pps_i};
         rise_q <= sync_q[1] & ~sync_q[2];
      end
   end

   // ---------------------------------------------------------------
   // Measurement FSM and counters
   // ---------------------------------------------------------------
   logic [1:0]                   state_q, state_d;
   logic [COUNT_WIDTH-1:0]       elapsed_q, elapsed_d;
   logic [COUNT_WIDTH-1:0]       win_cyc_q, win_cyc_d;
   logic [COUNT_WIDTH-1:0]       expected_q, expected_d;
   logic [3:0]                   per_cnt_q, per_cnt_d;
   logic [3:0]                   win_len_q, win_len_d;
   logic [UTC_SECONDS_WIDTH-1:0] utc_q, utc_d;
   logic [GLITCH_CNT_WIDTH-1:0]  glitch_q, glitch_d;
   logic                         win_start, win_end, timeout;
   logic [3:0]                   w_eff;

   assign timeout = (state_q == ST_MEASURE) && (elapsed_q == LOST_C);
   assign w_eff   = (window_len_i == 4'd0) ? 4'd1 : window_len_i;

   always_comb begin
      state_d    = state_q;
      elapsed_d  = (elapsed_q != '1) ? elapsed_q + COUNT_WIDTH'(1) : elapsed_q;
      win_cyc_d  = win_cyc_q + COUNT_WIDTH'(1);
      expected_d = expected_q;
      per_cnt_d  = per_cnt_q;
      win_len_d  = win_len_q;
      utc_d      = utc_q;
      glitch_d   = glitch_q;
      win_start  = 1'b0;
      win_end    = 1'b0;

      if (!enable_i) begin
         state_d = ST_IDLE;
         if (rise_q) elapsed_d = COUNT_WIDTH'(1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               // IDLE-exit edge starts a window but is not counted as a second
               if (rise_q) begin
                  elapsed_d = COUNT_WIDTH'(1);
                  win_start = 1'b1;
                  state_d   = ST_MEASURE;
               end
            end
            ST_HOLDOVER: begin
               if (rise_q) begin
                  elapsed_d = COUNT_WIDTH'(1);
                  utc_d     = utc_q + UTC_SECONDS_WIDTH'(1);
                  win_start = 1'b1;
                  state_d   = ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (timeout) begin
                  // A rise landing on the timeout cycle restarts measurement
                  // immediately instead of waiting for another edge.
                  state_d = ST_HOLDOVER;
                  if (rise_q) begin
                     elapsed_d = COUNT_WIDTH'(1);
                     utc_d     = utc_q + UTC_SECONDS_WIDTH'(1);
                     win_start = 1'b1;
                     state_d   = ST_MEASURE;
                  end
               end else if (rise_q) begin
                  if (elapsed_q < LO_C) begin
                     // Early edge: ignore it, keep the elapsed count running
                     if (glitch_q != '1) glitch_d = glitch_q + GLITCH_CNT_WIDTH'(1);
                  end else if (elapsed_q <= HI_C) begin
                     elapsed_d = COUNT_WIDTH'(1);
                     utc_d     = utc_q + UTC_SECONDS_WIDTH'(1);
                     if (per_cnt_q + 4'd1 == win_len_q) begin
                        win_end   = 1'b1;
                        win_start = 1'b1;   // back-to-back windows
                     end else begin
                        per_cnt_d = per_cnt_q + 4'd1;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (win_start) begin
         win_len_d  = w_eff;
         expected_d = NOM_C * COUNT_WIDTH'(w_eff);
         win_cyc_d  = COUNT_WIDTH'(1);
         per_cnt_d  = 4'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         elapsed_q  <= '0;
         win_cyc_q  <= '0;
         expected_q <= '0;
         per_cnt_q  <= '0;
         win_len_q  <= '0;
         utc_q      <= '0;
         glitch_q   <= '0;
      end else begin
         state_q    <= state_d;
         elapsed_q  <= elapsed_d;
         win_cyc_q  <= win_cyc_d;
         expected_q <= expected_d;
         per_cnt_q  <= per_cnt_d;
         win_len_q  <= win_len_d;
         utc_q      <= utc_d;
         glitch_q   <= glitch_d;
      end
   end

   // ---------------------------------------------------------------
   // Result pipeline: stage 1 subtracts, stage 2 saturates and loads
   // ---------------------------------------------------------------
   logic                          p1_vld_q;
   logic signed [COUNT_WIDTH:0]   p1_diff_q;
   logic [UTC_SECONDS_WIDTH-1:0]  p1_utc_q;
   logic [3:0]                    p1_win_q;
   logic signed [DRIFT_WIDTH-1:0] sat_drift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_vld_q  <= 1'b0;
         p1_diff_q <= '0;
         p1_utc_q  <= '0;
         p1_win_q  <= '0;
      end else begin
         p1_vld_q <= win_end;
         if (win_end) begin
            p1_diff_q <= $signed({1'b0, win_cyc_q}) - $signed({1'b0, expected_q});
            p1_utc_q  <= utc_d;
            p1_win_q  <= win_len_q;
         end
      end
   end

   always_comb begin
      sat_drift = p1_diff_q[DRIFT_WIDTH-1:0];
      if (p1_diff_q > SAT_MAX)      sat_drift = SAT_MAX[DRIFT_WIDTH-1:0];
      else if (p1_diff_q < SAT_MIN) sat_drift = SAT_MIN[DRIFT_WIDTH-1:0];
   end

   logic                          ev_valid_q;
   logic [UTC_SECONDS_WIDTH-1:0]  ev_utc_q;
   logic signed [DRIFT_WIDTH-1:0] ev_drift_q;
   logic [3:0]                    ev_win_q;
   logic                          ev_ovr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_valid_q <= 1'b0;
         ev_utc_q   <= '0;
         ev_drift_q <= '0;
         ev_win_q   <= '0;
         ev_ovr_q   <= 1'b0;
      end else begin
         // Loading while the old result is still pending and not being taken
         // this cycle loses that result.
         ev_ovr_q <= p1_vld_q & ev_valid_q & ~event_ready_i;
         if (p1_vld_q) begin
            ev_valid_q <= 1'b1;
            ev_utc_q   <= p1_utc_q;
            ev_drift_q <= sat_drift;
            ev_win_q   <= p1_win_q;
         end else if (ev_valid_q && event_ready_i) begin
            ev_valid_q <= 1'b0;
         end
      end
   end

`ifdef PPS_DRIFT_STATS_EN
   logic                          st_seen_q;
   logic signed [DRIFT_WIDTH-1:0] st_min_q, st_max_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_seen_q <= 1'b0;
         st_min_q  <= '0;
         st_max_q  <= '0;
      end else if (p1_vld_q) begin
         st_seen_q <= 1'b1;
         if (!st_seen_q || stats_clear_i) begin
            st_min_q <= sat_drift;
            st_max_q <= sat_drift;
         end else begin
            if (sat_drift < st_min_q) st_min_q <= sat_drift;
            if (sat_drift > st_max_q) st_max_q <= sat_drift;
         end
      end else if (stats_clear_i) begin
         st_seen_q <= 1'b0;
      end
   end

   assign drift_min_o = st_min_q;
   assign drift_max_o = st_max_q;
`endif

   assign event_valid_o       = ev_valid_q;
   assign event_utc_seconds_o = ev_utc_q;
   assign event_drift_o       = ev_drift_q;
   assign event_window_o      = ev_win_q;
   assign event_overrun_o     = ev_ovr_q;
   assign pps_lost_o          = timeout;
   assign glitch_count_o      = glitch_q;
   assign state_o             = state_q;

endmodule
